vlane_seq_divider: RTL



---
 rtl/vlane_seq_divider.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/vlane_seq_divider.sv
// vlane_seq_divider
// -----------------
// Multicycle radix-2 restoring divider behind the divide-unit port of a
// vector lane. It produces one WIDTH-bit quotient or remainder per request,
// following RISC-V div/divu/rem/remu semantics, including the divide-by-zero
// and signed-overflow results.
//
// Handshake: the lane pulses start_div for one cycle. The pulse is taken only
// while the unit is idle (busy_du = 0 and done_du = 0); a pulse at any other
// time is dropped. Operands are captured in that cycle and are not looked at
// again. done_du pulses once, for a single cycle, and wdata_du is valid from
// that cycle until the next accepted start. No backpressure is possible on
// the result side.
//
// Ports
//   CLK            clock, rising edge
//   nRST           asynchronous active-low reset
//   start_div      request strobe
//   vs2_data       dividend
//   vs1_data       divisor
//   div_type       0 = quotient, 1 = remainder
//   is_signed_div  1 = two's-complement operands, 0 = unsigned
//   wdata_du       result (registered)
//   busy_du        unit occupied (CALC/FIX)
//   done_du        one-cycle result-valid pulse
//   exception_du   tied to 0, divide faults never trap
//   state_dbg      current FSM state (0 IDLE, 1 CALC, 2 FIX, 3 DONE)

module vlane_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start_div,
  input  logic [WIDTH-1:0] vs2_data,
  input  logic [WIDTH-1:0] vs1_data,
  input  logic             div_type,
  input  logic             is_signed_div,
  output logic [WIDTH-1:0] wdata_du,
  output logic             busy_du,
  output logic             done_du,
  output logic             exception_du,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // Datapath registers. quo_q starts out holding the dividend magnitude and
  // is shifted left once per iteration; the dividend bit leaving the top
  // feeds the partial remainder while the new quotient bit enters at the
  // bottom, so after WIDTH iterations it holds the quotient magnitude.
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] divisor_q;
  logic [CW-1:0]    iter_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             type_q;

  // Start-cycle decode.
  logic             accept;
  logic             vs2_neg;
  logic             vs1_neg;
  logic [WIDTH-1:0] vs2_mag;
  logic [WIDTH-1:0] vs1_mag;
  logic             div_by_zero;
  logic             signed_ovf;
  logic             special;
  logic [WIDTH-1:0] special_res;

  // Iteration datapath.
  logic [WIDTH+1:0] partial;
  logic [WIDTH+1:0] trial;
  logic             q_bit;

  // Sign fix-up datapath.
  logic [WIDTH-1:0] quo_fixed;
  logic [WIDTH-1:0] rem_fixed;

  assign accept  = start_div && (state_q == S_IDLE);
  assign vs2_neg = is_signed_div && vs2_data[WIDTH-1];
  assign vs1_neg = is_signed_div && vs1_data[WIDTH-1];
  assign vs2_mag = vs2_neg ? (~vs2_data + ONE) : vs2_data;
  assign vs1_mag = vs1_neg ? (~vs1_data + ONE) : vs1_data;

  assign div_by_zero = (vs1_data == '0);
  assign signed_ovf  = is_signed_div && (vs2_data == MIN_NEG) && (vs1_data == '1);
  assign special     = div_by_zero || signed_ovf;

  // Divide-by-zero returns all ones / the untouched dividend; the signed
  // overflow case returns the dividend / zero. Both bypass the iteration.
  always_comb begin
    special_res = '0;
    if (div_by_zero) begin
      special_res = div_type ? vs2_data : '1;
    end else if (signed_ovf) begin
      special_res = div_type ? '0 : vs2_data;
    end
  end

  // Restoring step: shift the next dividend bit into the partial remainder
  // and trial-subtract the divisor. The remainder never exceeds the divisor,
  // so the extra top bit of trial is a clean borrow flag.
  assign partial = {rem_q, quo_q[WIDTH-1]};
  assign trial   = partial - {2'b00, divisor_q};
  assign q_bit   = ~trial[WIDTH+1];

  assign quo_fixed = neg_quo_q ? (~quo_q + ONE) : quo_q;
  assign rem_fixed = neg_rem_q ? (~rem_q[WIDTH-1:0] + ONE) : rem_q[WIDTH-1:0];

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_div) begin
          state_d = special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (iter_q == LAST_ITER) begin
          state_d = S_FIX;
        end
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe without a decode after the flops.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_du <= 1'b0;
      done_du <= 1'b0;
    end else begin
      busy_du <= (state_d == S_CALC) || (state_d == S_FIX);
      done_du <= (state_d == S_DONE);
    end
  end

  // Operand capture and iteration.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      iter_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      type_q    <= 1'b0;
    end else if (accept) begin
      quo_q     <= vs2_mag;
      rem_q     <= '0;
      divisor_q <= vs1_mag;
      iter_q    <= '0;
      neg_quo_q <= vs2_neg ^ vs1_neg;
      neg_rem_q <= vs2_neg;
      type_q    <= div_type;
    end else if (state_q == S_CALC) begin
      quo_q  <= {quo_q[WIDTH-2:0], q_bit};
      rem_q  <= q_bit ? trial[WIDTH:0] : partial[WIDTH:0];
      iter_q <= iter_q + CW'(1);
    end
  end

  // Result register: loaded directly for special cases at start, otherwise
  // in FIX once the sign corrections are applied.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wdata_du <= '0;
    end else if (accept && special) begin
      wdata_du <= special_res;
    end else if (state_q == S_FIX) begin
      wdata_du <= type_q ? rem_fixed : quo_fixed;
    end
  end

  assign exception_du = 1'b0;
  assign state_dbg    = state_q;

endmodule
